// File: rtl/ntt_pkg.sv
// Shared NTT datapath types: lane/vector typedefs and the TF generator state encoding.
package ntt_pkg;

  localparam int DW    = 64;
  localparam int LANES = 16;
  localparam int GW    = 16;

  typedef logic [DW-1:0]        tf_lane_t;
  typedef tf_lane_t [LANES-1:0] tf_vec_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tf_gen_state_e;

endpackage

// File: rtl/tf_stream_gen_if.sv
// Seed-load, run-control and output-stream signals of the twiddle-factor generator.
interface tf_stream_gen_if;
  import ntt_pkg::*;

  logic                ld_en;
  logic [3:0]          ld_idx;
  tf_lane_t            ld_tf;
  tf_lane_t            ld_step;
  logic                start;
  logic [GW-1:0]       num_groups;
  tf_lane_t            modulus;
  logic                out_ready;
  logic                out_valid;
  logic [LANES*DW-1:0] tf_out;
  tf_lane_t            mod_out;
  logic                busy;
  logic                done;

  modport master (
    output ld_en, ld_idx, ld_tf, ld_step, start, num_groups, modulus, out_ready,
    input  out_valid, tf_out, mod_out, busy, done
  );

  modport slave (
    input  ld_en, ld_idx, ld_tf, ld_step, start, num_groups, modulus, out_ready,
    output out_valid, tf_out, mod_out, busy, done
  );

endinterface

// File: rtl/mod_mul.sv
// Combinational modular multiply: (a * b) mod q over a full double-width product.
module mod_mul
  import ntt_pkg::*;
(
  input  tf_lane_t i_a,
  input  tf_lane_t i_b,
  input  tf_lane_t i_q,
  output tf_lane_t o_p
);

  logic [2*DW-1:0] w_full;

  assign w_full = {{DW{1'b0}}, i_a} * {{DW{1'b0}}, i_b};

  // q is zero only while no run is active; force a clean zero instead of a divide-by-zero.
  assign o_p = (i_q == '0) ? '0 : DW'(w_full % {{DW{1'b0}}, i_q});

endmodule

// File: rtl/tf_stream_gen.sv
// Twiddle-factor generator: 16 geometric lanes advanced by one modular multiply per accepted group.
module tf_stream_gen
  import ntt_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  tf_stream_gen_if.slave bus
);

  tf_gen_state_e r_state, w_nextState;
  tf_vec_t       r_cur, r_step, r_tfHold, w_prod;
  tf_lane_t      r_mod;
  logic [GW-1:0] r_num, r_count;
  logic          w_accept, w_last, w_startOk;

  assign w_accept  = (r_state == RUN) && bus.out_ready;
  assign w_last    = (r_count == r_num - GW'(1));
  assign w_startOk = bus.start && (bus.modulus != '0);

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    mod_mul u_mul (
      .i_a (r_cur[j]),
      .i_b (r_step[j]),
      .i_q (r_mod),
      .o_p (w_prod[j])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: if (w_startOk) w_nextState = (bus.num_groups != '0) ? RUN : DONE;
      RUN:  if (w_accept && w_last) w_nextState = DONE;
      DONE: w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Outside RUN the stream shows the last emitted group rather than the already-advanced lanes.
  always_comb begin
    bus.out_valid = (r_state == RUN);
    bus.busy      = (r_state == RUN);
    bus.done      = (r_state == DONE);
    bus.tf_out    = (r_state == RUN) ? r_cur : r_tfHold;
    bus.mod_out   = r_mod;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cur    <= '0;
      r_step   <= '0;
      r_tfHold <= '0;
      r_mod    <= '0;
      r_num    <= '0;
      r_count  <= '0;
    end else if (r_state == IDLE) begin
      if (bus.ld_en) begin
        r_cur[bus.ld_idx]  <= bus.ld_tf;
        r_step[bus.ld_idx] <= bus.ld_step;
      end
      if (w_startOk && (bus.num_groups != '0)) begin
        r_mod   <= bus.modulus;
        r_num   <= bus.num_groups;
        r_count <= '0;
      end
    end else if (w_accept) begin
      r_cur    <= w_prod;
      r_tfHold <= r_cur;
      r_count  <= r_count + GW'(1);
    end
  end

endmodule

// File: tb/tb_tf_stream_gen.sv
// Directed self-checking bench for tf_stream_gen: lane sequence, backpressure, edge starts, reset.
module tb_tf_stream_gen;
  import ntt_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  tf_lane_t seq [5] = '{64'd1, 64'd3, 64'd9, 64'd10, 64'd13};

  tf_stream_gen_if bus ();

  tf_stream_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic tf_vec_t expVec(input tf_lane_t v0);
    tf_vec_t v;
    for (int j = 0; j < LANES; j++) v[j] = (j == 0) ? v0 : 64'd1;
    return v;
  endfunction

  task automatic loadLane(input int idx, input tf_lane_t tf, input tf_lane_t st);
    bus.ld_en = 1'b1; bus.ld_idx = 4'(idx); bus.ld_tf = tf; bus.ld_step = st;
    @(negedge clk);
    bus.ld_en = 1'b0;
  endtask

  task automatic setupLanes();
    for (int j = 0; j < LANES; j++) loadLane(j, 64'd1, (j == 0) ? 64'd3 : 64'd1);
  endtask

  task automatic pulseStart(input logic [GW-1:0] n, input tf_lane_t q);
    bus.start = 1'b1; bus.num_groups = n; bus.modulus = q;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy_done got=%b%b exp=00", bus.busy, bus.done); end
    checks++; if (bus.tf_out !== '0 || bus.mod_out !== '0) begin failures++; $display("[TB] FAIL reset_data tf0=%h mod=%h exp=0", bus.tf_out[63:0], bus.mod_out); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lane_sequence();
    setupLanes();
    pulseStart(16'd5, 64'd17);
    for (int b = 0; b < 5; b++) begin
      checks++; if (bus.out_valid !== 1'b1 || bus.busy !== 1'b1) begin failures++; $display("[TB] FAIL seq_valid beat=%0d got=%b%b exp=11", b, bus.out_valid, bus.busy); end
      checks++; if (bus.tf_out !== expVec(seq[b])) begin failures++; $display("[TB] FAIL seq_tf beat=%0d lane0=%0d lane1=%0d exp=%0d,1", b, bus.tf_out[63:0], bus.tf_out[127:64], seq[b]); end
      checks++; if (bus.mod_out !== 64'd17) begin failures++; $display("[TB] FAIL seq_mod got=%0d exp=17", bus.mod_out); end
      @(negedge clk);
    end
    checks++; if (bus.done !== 1'b1 || bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL seq_done got done=%b valid=%b exp=1,0", bus.done, bus.out_valid); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL seq_done_pulse got done=%b busy=%b exp=0,0", bus.done, bus.busy); end
    checks++; if (bus.tf_out[63:0] !== 64'd13) begin failures++; $display("[TB] FAIL seq_hold got=%0d exp=13", bus.tf_out[63:0]); end
  endtask

  task automatic test_backpressure();
    int k = 0;
    setupLanes();
    pulseStart(16'd5, 64'd17);
    for (int c = 0; c < 12 && k < 5; c++) begin
      bus.out_ready = !(c == 1 || c == 2);
      checks++; if (bus.out_valid !== 1'b1 || bus.tf_out !== expVec(seq[k])) begin failures++; $display("[TB] FAIL bp_tf cycle=%0d valid=%b lane0=%0d exp=%0d", c, bus.out_valid, bus.tf_out[63:0], seq[k]); end
      if (bus.out_ready) k++;
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    checks++; if (k != 5) begin failures++; $display("[TB] FAIL bp_timeout beats=%0d exp=5", k); end
    checks++; if (bus.done !== 1'b1) begin failures++; $display("[TB] FAIL bp_done got=%b exp=1", bus.done); end
    @(negedge clk);
  endtask

  task automatic test_zero_groups();
    pulseStart(16'd0, 64'd17);
    checks++; if (bus.done !== 1'b1 || bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL zero_done got done=%b valid=%b exp=1,0", bus.done, bus.out_valid); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL zero_idle got %b%b%b exp=000", bus.done, bus.out_valid, bus.busy); end
  endtask

  task automatic test_invalid_modulus();
    pulseStart(16'd5, 64'd0);
    for (int c = 0; c < 2; c++) begin
      checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL badq cycle=%0d got busy=%b done=%b valid=%b exp=000", c, bus.busy, bus.done, bus.out_valid); end
      @(negedge clk);
    end
  endtask

  task automatic test_ignored_inputs();
    setupLanes();
    pulseStart(16'd5, 64'd17);
    for (int b = 0; b < 5; b++) begin
      checks++; if (bus.out_valid !== 1'b1 || bus.tf_out !== expVec(seq[b]) || bus.mod_out !== 64'd17) begin failures++; $display("[TB] FAIL ign_tf beat=%0d valid=%b lane0=%0d mod=%0d exp=1,%0d,17", b, bus.out_valid, bus.tf_out[63:0], bus.mod_out, seq[b]); end
      if (b == 1) begin
        bus.start = 1'b1; bus.num_groups = 16'd2; bus.modulus = 64'd7;
        bus.ld_en = 1'b1; bus.ld_idx = 4'd0; bus.ld_tf = 64'd11; bus.ld_step = 64'd2;
      end
      @(negedge clk);
      bus.start = 1'b0; bus.ld_en = 1'b0;
    end
    checks++; if (bus.done !== 1'b1) begin failures++; $display("[TB] FAIL ign_done got=%b exp=1", bus.done); end
    @(negedge clk);
    pulseStart(16'd1, 64'd17);
    checks++; if (bus.tf_out[63:0] !== 64'd5) begin failures++; $display("[TB] FAIL ign_continue got=%0d exp=5", bus.tf_out[63:0]); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b1) begin failures++; $display("[TB] FAIL ign_single_done got=%b exp=1", bus.done); end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    setupLanes();
    pulseStart(16'd5, 64'd17);
    repeat (2) @(negedge clk);
    checks++; if (bus.tf_out[63:0] !== 64'd9) begin failures++; $display("[TB] FAIL rst_pre got=%0d exp=9", bus.tf_out[63:0]); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_async_ctrl got valid=%b busy=%b exp=0,0", bus.out_valid, bus.busy); end
    checks++; if (bus.tf_out !== '0 || bus.mod_out !== '0) begin failures++; $display("[TB] FAIL rst_async_data tf0=%h mod=%h exp=0", bus.tf_out[63:0], bus.mod_out); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    setupLanes();
    pulseStart(16'd5, 64'd17);
    for (int b = 0; b < 5; b++) begin
      checks++; if (bus.out_valid !== 1'b1 || bus.tf_out !== expVec(seq[b])) begin failures++; $display("[TB] FAIL rst_rerun beat=%0d valid=%b lane0=%0d exp=%0d", b, bus.out_valid, bus.tf_out[63:0], seq[b]); end
      @(negedge clk);
    end
    checks++; if (bus.done !== 1'b1) begin failures++; $display("[TB] FAIL rst_rerun_done got=%b exp=1", bus.done); end
    @(negedge clk);
  endtask

  initial begin
    bus.ld_en = 1'b0; bus.ld_idx = '0; bus.ld_tf = '0; bus.ld_step = '0;
    bus.start = 1'b0; bus.num_groups = '0; bus.modulus = '0; bus.out_ready = 1'b1;
    test_reset();
    test_lane_sequence();
    test_backpressure();
    test_zero_groups();
    test_invalid_modulus();
    test_ignored_inputs();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
